// File: rtl/img_pkg.sv
// ---------------------------------------------------------------------------
// img_pkg
// Shared types and constants for the RGB image pipeline.
//   pixel_t          : 8-bit red/green/blue triple
//   *_MSB / *_LSB    : bit positions of each colour in a packed 24-bit RAM word
//   IMG_W_DEF/H_DEF  : default frame geometry
//   streamer_state_t : pixel_streamer FSM states
// ---------------------------------------------------------------------------
package img_pkg;

    localparam int IMG_W_DEF = 256;
    localparam int IMG_H_DEF = 256;

    localparam int R_MSB = 23;
    localparam int R_LSB = 16;
    localparam int G_MSB = 15;
    localparam int G_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } streamer_state_t;

endpackage

// File: rtl/pixel_streamer_raster_counter.sv
// ---------------------------------------------------------------------------
// raster_counter
// Column/row/linear-index counters for raster-order frame traversal.
//   clk, rst      : clock, synchronous active-high reset
//   i_clr         : synchronous clear of all counters
//   i_adv         : advance one pixel
//   o_index       : linear pixel index (RAM address)
//   o_last_col    : current column is the last of its row
//   o_last_pixel  : current pixel is the last of the frame
// ---------------------------------------------------------------------------
module raster_counter
    import img_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = 16,
    parameter int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    parameter int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_adv,
    output logic [ADDR_W-1:0] o_index,
    output logic              o_last_col,
    output logic              o_last_pixel
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [ADDR_W-1:0] r_idx;

    assign o_last_col   = (r_col == LAST_COL);
    assign o_last_pixel = o_last_col && (r_row == LAST_ROW);
    assign o_index      = r_idx;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_col <= '0;
            r_row <= '0;
            r_idx <= '0;
        end else if (i_adv) begin
            if (o_last_col) begin
                r_col <= '0;
                r_row <= (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
            // Index parks on the final pixel so the address never wraps
            // even when the frame exactly fills the address space.
            if (!o_last_pixel) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_streamer.sv
// ---------------------------------------------------------------------------
// pixel_streamer
// Reads one frame from a synchronous-read pixel RAM in raster order and
// presents each pixel as R/G/B with a one-cycle done_o strobe.
//   clk, rst        : clock, synchronous active-high reset
//   start_i         : begin a frame (only honoured in IDLE)
//   hold_i          : suppress new RAM reads
//   mem_rd_o        : RAM read enable (combinational)
//   mem_addr_o      : RAM read address (registered pixel index)
//   mem_data_i      : RAM data, valid the cycle after mem_rd_o
//   red/green/blue_o: current pixel, held between strobes
//   done_o, eol_o   : pixel strobe, end-of-line tag
//   frame_done_o    : pulse the cycle after the final done_o
//   busy_o          : frame in progress
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start_i
// RUN   | issuing reads, paced by gap counter and hold_i
// DRAIN | all reads issued, waiting for the last pixel to be emitted
// DONE  | frame_done_o pulse, back to IDLE
// ---------------------------------------------------------------------------
module pixel_streamer
    import img_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = 16,
    parameter int GAP    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              hold_i,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [23:0]       mem_data_i,
    output logic [7:0]        red_o,
    output logic [7:0]        green_o,
    output logic [7:0]        blue_o,
    output logic              done_o,
    output logic              eol_o,
    output logic              frame_done_o,
    output logic              busy_o
);

    localparam int             GAP_W    = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP);

    streamer_state_t r_state, w_state_nxt;

    logic [GAP_W-1:0] r_gap;
    logic             w_issue;
    logic             w_cnt_clr;
    logic             w_last_col;
    logic             w_last_pixel;

    logic             r_vld;
    logic             r_vld_eol;
    logic             r_done;
    logic             r_eol;
    pixel_t           r_pix;

    raster_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_raster (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_cnt_clr),
        .i_adv        (w_issue),
        .o_index      (mem_addr_o),
        .o_last_col   (w_last_col),
        .o_last_pixel (w_last_pixel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_cnt_clr   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_issue = !hold_i && (r_gap == '0);
                if (w_issue && w_last_pixel) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Last strobe is on done_o with nothing left in the pipe.
                if (r_done && !r_vld) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Gap counter keeps running under hold_i so pacing is not stretched.
    always_ff @(posedge clk) begin
        if (rst || w_cnt_clr) begin
            r_gap <= '0;
        end else if (w_issue) begin
            r_gap <= GAP_LOAD;
        end else if (r_gap != '0) begin
            r_gap <= r_gap - 1'b1;
        end
    end

    // Return path: issue -> valid stage (data arrives) -> colour regs + strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld     <= 1'b0;
            r_vld_eol <= 1'b0;
            r_done    <= 1'b0;
            r_eol     <= 1'b0;
            r_pix     <= '0;
        end else begin
            r_vld     <= w_issue;
            r_vld_eol <= w_issue && w_last_col;
            r_done    <= r_vld;
            r_eol     <= r_vld && r_vld_eol;
            if (r_vld) begin
                r_pix.r <= mem_data_i[R_MSB:R_LSB];
                r_pix.g <= mem_data_i[G_MSB:G_LSB];
                r_pix.b <= mem_data_i[B_MSB:B_LSB];
            end
        end
    end

    assign mem_rd_o     = w_issue;
    assign red_o        = r_pix.r;
    assign green_o      = r_pix.g;
    assign blue_o       = r_pix.b;
    assign done_o       = r_done;
    assign eol_o        = r_eol;
    assign frame_done_o = (r_state == DONE);
    assign busy_o       = (r_state != IDLE);

endmodule

// File: tb/tb_pixel_streamer.sv
module tb_pixel_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  start_v;
    logic        hold;

    logic [2:0]  rd_w, done_w, eol_w, fd_w, busy_w;
    logic [15:0] addr_w [3];
    logic [23:0] mdata  [3];
    logic [7:0]  red_w  [3];
    logic [7:0]  grn_w  [3];
    logic [7:0]  blu_w  [3];

    int cyc = 0;
    int t0 = 0;
    int sel = 0;
    int exp_fd = 0;
    int fd_count = 0;
    int n_chk = 0;
    int n_pass = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [23:0] rgb;
        logic        eol;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    // 0: 4x2 GAP=0   1: 4x2 GAP=2   2: 1x1 GAP=0
    pixel_streamer #(.IMG_W(4), .IMG_H(2), .ADDR_W(16), .GAP(0)) u_dut0 (
        .clk(clk), .rst(rst), .start_i(start_v[0]), .hold_i(hold),
        .mem_rd_o(rd_w[0]), .mem_addr_o(addr_w[0]), .mem_data_i(mdata[0]),
        .red_o(red_w[0]), .green_o(grn_w[0]), .blue_o(blu_w[0]),
        .done_o(done_w[0]), .eol_o(eol_w[0]), .frame_done_o(fd_w[0]), .busy_o(busy_w[0])
    );
    pixel_streamer #(.IMG_W(4), .IMG_H(2), .ADDR_W(16), .GAP(2)) u_dut1 (
        .clk(clk), .rst(rst), .start_i(start_v[1]), .hold_i(hold),
        .mem_rd_o(rd_w[1]), .mem_addr_o(addr_w[1]), .mem_data_i(mdata[1]),
        .red_o(red_w[1]), .green_o(grn_w[1]), .blue_o(blu_w[1]),
        .done_o(done_w[1]), .eol_o(eol_w[1]), .frame_done_o(fd_w[1]), .busy_o(busy_w[1])
    );
    pixel_streamer #(.IMG_W(1), .IMG_H(1), .ADDR_W(16), .GAP(0)) u_dut2 (
        .clk(clk), .rst(rst), .start_i(start_v[2]), .hold_i(hold),
        .mem_rd_o(rd_w[2]), .mem_addr_o(addr_w[2]), .mem_data_i(mdata[2]),
        .red_o(red_w[2]), .green_o(grn_w[2]), .blue_o(blu_w[2]),
        .done_o(done_w[2]), .eol_o(eol_w[2]), .frame_done_o(fd_w[2]), .busy_o(busy_w[2])
    );

    function automatic logic [23:0] ram_word(input logic [15:0] a);
        logic [7:0] k;
        k = a[7:0];
        return {k, k + 8'd8, k + 8'd16};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (rd_w[i]) mdata[i] <= ram_word(addr_w[i]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc - t0);
        end
    endtask

    task automatic chk_idle(input int i);
        chk("rst_rd",    32'(rd_w[i]),   0);
        chk("rst_addr",  32'(addr_w[i]), 0);
        chk("rst_rgb",   32'({red_w[i], grn_w[i], blu_w[i]}), 0);
        chk("rst_done",  32'(done_w[i]), 0);
        chk("rst_eol",   32'(eol_w[i]),  0);
        chk("rst_fd",    32'(fd_w[i]),   0);
        chk("rst_busy",  32'(busy_w[i]), 0);
    endtask

    int   mrel;
    exp_t me;
    always @(negedge clk) begin
        if (mon_en) begin
            mrel = cyc - t0;
            if (done_w[sel]) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", 32'(done_w[sel]), 0);
                end else begin
                    me = sb.pop_front();
                    chk("done_cycle", mrel, me.cyc);
                    chk("rgb", 32'({red_w[sel], grn_w[sel], blu_w[sel]}), 32'(me.rgb));
                    chk("eol", 32'(eol_w[sel]), 32'(me.eol));
                end
            end else if (eol_w[sel]) begin
                chk("eol_without_done", 32'(eol_w[sel]), 0);
            end
            if (fd_w[sel]) begin
                chk("frame_done_cycle", mrel, exp_fd);
                fd_count <= fd_count + 1;
            end
        end
    end

    // Expected schedule: issue when not held and gap is zero; strobe two
    // cycles later; frame_done one cycle after the final strobe.
    task automatic run_frame(input int s, input int w, input int h, input int gap,
                             input int hlo, input int hhi);
        int t, k, g, fd_base;
        exp_t e;
        sb.delete();
        t = 1; k = 0; g = 0;
        while (k < w * h) begin
            if (!(t >= hlo && t <= hhi) && g == 0) begin
                e.rgb = ram_word(16'(k));
                e.eol = ((k % w) == w - 1);
                e.cyc = t + 2;
                sb.push_back(e);
                k++;
                g = gap;
            end else if (g > 0) begin
                g--;
            end
            t++;
        end
        exp_fd = sb[sb.size() - 1].cyc + 1;
        sel = s;
        fd_base = fd_count;
        @(posedge clk); #1;
        t0 = cyc;
        mon_en = 1'b1;
        for (int r = 0; r <= exp_fd + 1; r++) begin
            start_v = (r == 0) ? 3'(1 << s) : 3'b000;
            hold    = (r >= hlo && r <= hhi);
            @(negedge clk);
            if (r == 1) begin
                chk("first_rd",   32'(rd_w[s]),   1);
                chk("first_addr", 32'(addr_w[s]), 0);
                chk("busy_c1",    32'(busy_w[s]), 1);
            end
            if (r == exp_fd) chk("busy_fd_cycle", 32'(busy_w[s]), 1);
            if (r == exp_fd + 1) begin
                chk("busy_after", 32'(busy_w[s]), 0);
                chk("fd_pulses",  fd_count - fd_base, 1);
                chk("pixels_left", sb.size(), 0);
            end
            @(posedge clk); #1;
        end
        mon_en  = 1'b0;
        hold    = 1'b0;
        start_v = 3'b000;
    endtask

    task automatic abort_frame();
        sel = 0;
        sb.delete();
        mon_en = 1'b0;
        @(posedge clk); #1;
        t0 = cyc;
        for (int r = 0; r <= 7; r++) begin
            start_v = (r == 0 || r == 5) ? 3'b001 : 3'b000;
            rst     = (r == 6);
            @(negedge clk);
            if (r == 6) begin
                chk("no_restart_addr", 32'(addr_w[0]), 5);
                chk("no_restart_busy", 32'(busy_w[0]), 1);
            end
            if (r == 7) chk_idle(0);
            @(posedge clk); #1;
        end
        rst     = 1'b0;
        start_v = 3'b000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        start_v = 3'b111;
        hold    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk_idle(i);
        @(posedge clk); #1;
        rst     = 1'b0;
        start_v = 3'b000;

        run_frame(0, 4, 2, 0, -1, -2);   // basic
        run_frame(1, 4, 2, 2, -1, -2);   // pacing
        run_frame(0, 4, 2, 0,  2,  4);   // hold in cycles 2-4
        abort_frame();                   // ignored start + mid-frame reset
        run_frame(0, 4, 2, 0, -1, -2);   // full frame after reset
        run_frame(2, 1, 1, 0, -1, -2);   // 1x1 image

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pixel_streamer.md
# pixel_streamer

Frame source for the RGB filter pipeline. After a start command it reads one image from a synchronous-read pixel RAM in raster order. It presents each pixel as 8-bit red/green/blue with a one-cycle `done_o` strobe, which is the per-pixel strobe the filter consumes on its `done_i`. Pacing comes from a GAP parameter and a `hold_i` throttle, and the block flags end-of-line and end-of-frame.

## Interface
- `IMG_W`, default 256: pixels per row, must be ≥ 1.
- `IMG_H`, default 256: rows per frame, must be ≥ 1.
- `ADDR_W`, default 16: RAM address width, with 2^ADDR_W ≥ IMG_W*IMG_H.
- `GAP`, default 0: idle cycles forced between consecutive pixel reads.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_i`  in  1  begin one frame; sampled only in IDLE.
- `hold_i`  in  1  suppress new RAM reads while high.
- `mem_rd_o`  out  1  RAM read enable (combinational, see Operation).
- `mem_addr_o`  out  ADDR_W  RAM read address (registered pixel index).
- `mem_data_i`  in  24  RAM data, valid the cycle after `mem_rd_o`; packing is [23:16]=R, [15:8]=G, [7:0]=B.
- `red_o`, `green_o`, `blue_o`  out  8 each  current pixel; each holds its value when `done_o` is low.
- `done_o`  out  1  one-cycle pixel strobe.
- `eol_o`  out  1  high together with `done_o` on the last pixel of each row.
- `frame_done_o`  out  1  one-cycle pulse the cycle after the final `done_o`.
- `busy_o`  out  1  frame in progress.

## Operation
- FSM states:
  - **IDLE**: on `start_i`=1, clear the pixel index and the gap counter, then go to RUN.
  - **RUN**: `mem_rd_o` = !`hold_i` && gap_cnt==0. On each issue:
    - index++;
    - gap_cnt loads GAP;
    - on the issue of pixel IMG_W*IMG_H-1, go to DRAIN.
  - **DRAIN**: wait for the final read data and its output register to empty. Go to DONE in the cycle the last `done_o` is high.
  - **DONE**: assert `frame_done_o` for one cycle, then return to IDLE.
- Gap counter:
  - When nonzero it decrements every cycle, regardless of `hold_i`.
  - With GAP=0, pixels issue back-to-back.
- Return path: the issue is registered into a valid/eol pipeline stage. The cycle after an issue, `mem_data_i` is captured into the colour registers and `done_o` is set for the following cycle.
- `hold_i` gates only issues. A read already issued is always emitted. There is no skid buffer and no data loss.
- Column/row counters advance on each issue. `eol_o` is tagged when col==IMG_W-1; col wraps to 0 and row increments.
- `mem_addr_o` = pixel index. It increments linearly from 0 to IMG_W*IMG_H-1 and never wraps within a frame.
- `start_i` is ignored in RUN, DRAIN and DONE.
- `rst` at any time, including mid-frame:
  - the next state is IDLE;
  - all counters clear;
  - any in-flight pixel is discarded.

## Timing
- Reset value of every output is 0: `mem_rd_o`, `mem_addr_o`, colours, `done_o`, `eol_o`, `frame_done_o`, `busy_o`.
- Latency, with `start_i` sampled at the end of cycle 0:
  - first `mem_rd_o` is in cycle 1;
  - data is valid in cycle 2;
  - first `done_o` is in cycle 3.
- Issue in cycle t gives `done_o` in cycle t+2, with no exceptions.
- `hold_i` high in cycle t means no issue in t. Its effect on `done_o` appears at t+2.
- `busy_o` is high from cycle 1 through the `frame_done_o` cycle inclusive.
- `start_i` is accepted again from the cycle after `frame_done_o`.
- Steady-state throughput is one pixel per (GAP+1) cycles when `hold_i` is low.

## Structure
- Shared package `img_pkg` holds:
  - `pixel_t` struct (r, g, b, each 8 bits);
  - RGB packing bit-position constants;
  - default IMG_W/IMG_H;
  - the streamer state enum (IDLE, RUN, DRAIN, DONE).
- One sub-module, `raster_counter`: col/row/index counters with an advance enable, clear, and `last_col`/`last_pixel` flags.
- The FSM, gap counter and return pipeline stay in the top level.

## Test plan
- **Reset:** hold `rst` for 3 cycles with `start_i`=1 → all outputs 0, no `mem_rd_o`.
- **Basic frame:** IMG_W=4, IMG_H=2, GAP=0, RAM[k]={k, k+8, k+16}, start in cycle 0 →
  - `done_o` high in cycles 3–10 with red = 0..7;
  - `eol_o` high in cycles 6 and 10;
  - `frame_done_o` in cycle 11;
  - `busy_o` low in cycle 12.
- **Pacing:** GAP=2, same image → `done_o` in cycles 3, 6, 9, …, 24; `frame_done_o` in cycle 25.
- **Hold:** GAP=0, `hold_i`=1 in cycles 2–4 →
  - addr 0 is issued in cycle 1 and emitted in cycle 3;
  - no `done_o` in cycles 4–6;
  - addr 1 is issued in cycle 5, giving `done_o` in cycle 7;
  - the total of 8 pixels is unchanged.
- **Ignored start and mid-frame reset:** pulse `start_i` in cycle 5 → no restart. Assert `rst` in cycle 6 → all outputs 0 in cycle 7. Start again → `mem_addr_o` restarts at 0, and the full 8-pixel frame completes.
- **Boundary image:** IMG_W=1, IMG_H=1 → exactly one `done_o` (cycle 3) with `eol_o`=1, and `frame_done_o` in cycle 4.
